vga_timing_gen: RTL and testbench

//  Upstream stage of the image controller. Generates 640x480@60 VGA raster timing.

---
 rtl/vga_timing_gen_if.sv | 29 ++
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-side bundle between the VGA timing generator and
// the image controller / VGA pins.
interface vga_timing_gen_if;
   logic [7:0] memRGB;
   logic [9:0] x;
   logic [9:0] y;
   logic       PIX_EN;
   logic       FRAME_CLOCK;
   logic       VIDEO_ON;
   logic       HSYNC;
   logic       VSYNC;
   logic [2:0] VGA_R;
   logic [2:0] VGA_G;
   logic [1:0] VGA_B;

   // Timing generator side: drives raster position, strobes and pins.
   modport master (
      input  memRGB,
      output x, y, PIX_EN, FRAME_CLOCK, VIDEO_ON, HSYNC, VSYNC,
             VGA_R, VGA_G, VGA_B
   );

   // Image controller / pin side: returns colour for the current x/y.
   modport slave (
      output memRGB,
      input  x, y, PIX_EN, FRAME_CLOCK, VIDEO_ON, HSYNC, VSYNC,
             VGA_R, VGA_G, VGA_B
   );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator (640x480@60 by default).
// Divides CLK_IN into a one-cycle pixel strobe, walks x/y over the full
// raster, and registers blanked colour plus sync with one pixel period of
// latency so colour and sync stay aligned at the pins.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0
) (
   input  logic             CLK_IN,
   input  logic             RST_N,
   vga_timing_gen_if.master vga
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   // Divider state
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             pix_en_q,  pix_en_d;

   // Raster position
   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;

   // Registered pin-side outputs
   logic             video_on_q,    video_on_d;
   logic             hsync_q,       hsync_d;
   logic             vsync_q,       vsync_d;
   logic             frame_clock_q, frame_clock_d;
   logic [7:0]       rgb_q,         rgb_d;

   // Decoded regions of the pre-advance raster position
   logic             line_end;
   logic             frame_end;
   logic             in_active;
   logic             in_hsync;
   logic             in_vsync;
   logic             on_frame_line;

   // Pixel divider: PIX_EN is registered, so it is computed from the next
   // divider count; this keeps it glitch-free and high exactly while
   // div_cnt sits at its last value.
   always_comb begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_ONE;
      pix_en_d  = (div_cnt_d == DIV_LAST);
   end

   // Raster region decode from the current (pre-advance) position.
   always_comb begin
      line_end      = (x_q == X_LAST);
      frame_end     = (y_q == Y_LAST);
      in_active     = (x_q < X_ACT) && (y_q < Y_ACT);
      in_hsync      = (x_q >= HS_START) && (x_q < HS_END);
      in_vsync      = (y_q >= VS_START) && (y_q < VS_END);
      on_frame_line = (y_q == Y_ACT);
   end

   // Raster counters advance only on the pixel strobe.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (pix_en_q) begin
         if (line_end) begin
            x_d = '0;
            y_d = frame_end ? '0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end
   end

   // Output pipeline: load blanked colour, syncs and frame flag together on
   // the pixel strobe; hold them in between.
   always_comb begin
      video_on_d    = video_on_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      frame_clock_d = frame_clock_q;
      rgb_d         = rgb_q;
      if (pix_en_q) begin
         video_on_d    = in_active;
         hsync_d       = in_hsync ^ ~HS_POL;
         vsync_d       = in_vsync ^ ~VS_POL;
         frame_clock_d = on_frame_line;
         rgb_d         = in_active ? vga.memRGB : 8'h00;
      end
   end

   // State registers with asynchronous active-low reset; syncs reset inactive.
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         div_cnt_q     <= '0;
         pix_en_q      <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         video_on_q    <= 1'b0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         frame_clock_q <= 1'b0;
         rgb_q         <= '0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         pix_en_q      <= pix_en_d;
         x_q           <= x_d;
         y_q           <= y_d;
         video_on_q    <= video_on_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         frame_clock_q <= frame_clock_d;
         rgb_q         <= rgb_d;
      end
   end

   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.PIX_EN      = pix_en_q;
   assign vga.FRAME_CLOCK = frame_clock_q;
   assign vga.VIDEO_ON    = video_on_q;
   assign vga.HSYNC       = hsync_q;
   assign vga.VSYNC       = vsync_q;
   assign vga.VGA_R       = rgb_q[7:5];
   assign vga.VGA_G       = rgb_q[4:2];
   assign vga.VGA_B       = rgb_q[1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// Instance A uses the default 640x480 timing with CLK_DIV=4 over the first
// ten lines; instance B uses a tiny raster with CLK_DIV=1 and an active-high
// HSYNC so whole frames, vertical blanking and a mid-frame reset fit in a
// short run.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       von;
      logic       hs;
      logic       vs;
      logic       fc;
      logic [7:0] rgb;
   } exp_t;

   localparam int unsigned A_PIXELS = 8020;   // reaches past (10,10)

   logic        clk = 1'b0;
   logic        rst_a_n;
   logic        rst_b_n;
   int unsigned checks = 0;
   int unsigned errors = 0;
   exp_t        q_a[$];
   exp_t        q_b[$];

   always #5 clk = ~clk;

   vga_timing_gen_if ifa ();
   vga_timing_gen_if ifb ();

   vga_timing_gen u_a (
      .CLK_IN (clk),
      .RST_N  (rst_a_n),
      .vga    (ifa)
   );

   vga_timing_gen #(
      .CLK_DIV  (1),
      .H_ACTIVE (16),
      .H_FP     (4),
      .H_SYNC   (6),
      .H_BP     (6),
      .V_ACTIVE (12),
      .V_FP     (2),
      .V_SYNC   (2),
      .V_BP     (3),
      .HS_POL   (1'b1),
      .VS_POL   (1'b0)
   ) u_b (
      .CLK_IN (clk),
      .RST_N  (rst_b_n),
      .vga    (ifb)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t act_a();
      return {ifa.x, ifa.y, ifa.VIDEO_ON, ifa.HSYNC, ifa.VSYNC, ifa.FRAME_CLOCK,
              ifa.VGA_R, ifa.VGA_G, ifa.VGA_B};
   endfunction

   function automatic exp_t act_b();
      return {ifb.x, ifb.y, ifb.VIDEO_ON, ifb.HSYNC, ifb.VSYNC, ifb.FRAME_CLOCK,
              ifb.VGA_R, ifb.VGA_G, ifb.VGA_B};
   endfunction

   // 640x480: total 800x525, hsync 656..751 low, vsync 490..491 low.
   function automatic exp_t model_a(input int unsigned xm, input int unsigned ym,
                                    input logic [7:0] mem);
      exp_t e;
      e.von = (xm < 640) && (ym < 480);
      e.hs  = !((xm >= 656) && (xm < 752));
      e.vs  = !((ym >= 490) && (ym < 492));
      e.fc  = (ym == 480);
      e.rgb = e.von ? mem : 8'h00;
      e.x   = (xm == 799) ? 10'd0 : 10'(xm + 1);
      e.y   = (xm != 799) ? 10'(ym) : ((ym == 524) ? 10'd0 : 10'(ym + 1));
      return e;
   endfunction

   // Tiny raster: total 32x19, hsync 20..25 high, vsync 14..15 low.
   function automatic exp_t model_b(input int unsigned xm, input int unsigned ym,
                                    input logic [7:0] mem);
      exp_t e;
      e.von = (xm < 16) && (ym < 12);
      e.hs  = (xm >= 20) && (xm < 26);
      e.vs  = !((ym >= 14) && (ym < 16));
      e.fc  = (ym == 12);
      e.rgb = e.von ? mem : 8'h00;
      e.x   = (xm == 31) ? 10'd0 : 10'(xm + 1);
      e.y   = (xm != 31) ? 10'(ym) : ((ym == 18) ? 10'd0 : 10'(ym + 1));
      return e;
   endfunction

   task automatic stim_a();
      int unsigned xm;
      int unsigned ym;
      exp_t        e;
      logic [7:0]  mem;
      rst_a_n = 1'b0;
      ifa.memRGB = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("a_reset_out", act_a(), {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
      chk("a_reset_pix_en", 32'(ifa.PIX_EN), 32'd0);
      @(negedge clk);
      rst_a_n = 1'b1;
      xm = 0;
      ym = 0;
      for (int p = 0; p < int'(A_PIXELS); p++) begin
         if (xm == 10 && ym == 10)  mem = 8'b101_110_01;
         else if (ym % 3 == 1)      mem = 8'hFF;
         else                       mem = 8'(xm * 7 + ym);
         ifa.memRGB = mem;
         e = model_a(xm, ym, mem);
         for (int s = 1; s <= 4; s++) begin
            if (s == 4) q_a.push_back(e);
            @(posedge clk);
            #1;
            chk("a_pix_en", 32'(ifa.PIX_EN), 32'(s == 3));
         end
         xm = e.x;
         ym = e.y;
      end
      rst_a_n = 1'b0;
   endtask

   task automatic stim_b();
      int unsigned xm;
      int unsigned ym;
      int unsigned npix;
      exp_t        e;
      logic [7:0]  mem;
      rst_b_n = 1'b0;
      ifb.memRGB = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("b_reset_out", act_b(), {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
      chk("b_reset_pix_en", 32'(ifb.PIX_EN), 32'd0);
      for (int run = 0; run < 2; run++) begin
         @(negedge clk);
         rst_b_n = 1'b1;
         @(posedge clk);
         #1;
         chk("b_pix_en_first", 32'(ifb.PIX_EN), 32'd1);
         xm = 0;
         ym = 0;
         // run 0 stops right after the edge that sampled (10,8)
         npix = (run == 0) ? 1483 : 613;
         for (int p = 0; p < int'(npix); p++) begin
            if (run == 0 && p < 608) mem = 8'hFF;
            else                     mem = {xm[2:0], ym[2:0], xm[4:3]};
            ifb.memRGB = mem;
            e = model_b(xm, ym, mem);
            q_b.push_back(e);
            @(posedge clk);
            #1;
            chk("b_pix_en", 32'(ifb.PIX_EN), 32'd1);
            xm = e.x;
            ym = e.y;
         end
         if (run == 0) begin
            chk("b_pre_reset_video_on", 32'(ifb.VIDEO_ON), 32'd1);
            #2;
            rst_b_n = 1'b0;
            #1;
            chk("b_async_reset_out", act_b(), {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
            chk("b_async_reset_pix_en", 32'(ifb.PIX_EN), 32'd0);
            repeat (2) @(posedge clk);
         end
      end
      rst_b_n = 1'b0;
   endtask

   // Monitor A: every edge that closes a pixel period must match the next
   // queued expectation.
   initial begin : mon_a
      logic pe;
      exp_t e;
      forever begin
         @(negedge clk);
         pe = ifa.PIX_EN;
         @(posedge clk);
         if (pe && rst_a_n) begin
            #1;
            if (q_a.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_unexpected_pixel: got x=%0d y=%0d expected no output", ifa.x, ifa.y);
            end else begin
               e = q_a.pop_front();
               chk($sformatf("a_pixel_to(%0d,%0d)", e.x, e.y), act_a(), e);
            end
         end
      end
   end

   // Monitor B: same scoreboard plus frame-to-frame FRAME_CLOCK spacing.
   initial begin : mon_b
      logic        pe;
      logic        fc_prev;
      bit          have_rise;
      int unsigned since;
      exp_t        e;
      fc_prev   = 1'b0;
      have_rise = 1'b0;
      since     = 0;
      forever begin
         @(negedge clk);
         pe = ifb.PIX_EN;
         @(posedge clk);
         if (!rst_b_n) begin
            fc_prev   = 1'b0;
            have_rise = 1'b0;
            since     = 0;
         end else if (pe) begin
            #1;
            if (q_b.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_unexpected_pixel: got x=%0d y=%0d expected no output", ifb.x, ifb.y);
            end else begin
               e = q_b.pop_front();
               chk($sformatf("b_pixel_to(%0d,%0d)", e.x, e.y), act_b(), e);
            end
            since++;
            if (ifb.FRAME_CLOCK && !fc_prev) begin
               if (have_rise) chk("b_frame_period", since, 32'd608);
               have_rise = 1'b1;
               since     = 0;
            end
            fc_prev = ifb.FRAME_CLOCK;
         end
      end
   end

   initial begin : main
      fork
         stim_a();
         stim_b();
      join
      repeat (4) @(posedge clk);
      #1;
      chk("a_queue_drained", q_a.size(), 32'd0);
      chk("b_queue_drained", q_b.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
